// File: rtl/ptp_perout_ctrl_if.sv
// Configuration channel of the periodic-output controller: one valid/ready
// transfer carries period, width and first-edge phase together.
interface ptp_perout_ctrl_if;
  // Transfer happens on a rising clk edge where cfg_valid and cfg_ready are both high;
  // the master holds valid and data stable until that edge.
  logic        cfg_valid;
  logic        cfg_ready;
  logic [95:0] cfg_period;
  logic [95:0] cfg_width;
  logic [29:0] cfg_phase_ns;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_width,
    output cfg_phase_ns,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_width,
    input  cfg_phase_ns,
    output cfg_ready
  );
endinterface

// File: rtl/ptp_perout_ctrl.sv
// Sequences period/width/start loads into a PTP periodic-output generator,
// waits for lock, retries on error/timeout and parks in FAULT after MAX_RETRY.
module ptp_perout_ctrl #(
  parameter logic [47:0] LEAD_S       = 48'd2,
  parameter int          LOCK_TIMEOUT = 1024,
  parameter int          MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [95:0]               input_ts_96,
  input  logic                      input_ts_step,
  input  logic                      enable_req,
  ptp_perout_ctrl_if.slave          cfg_if,
  input  logic                      perout_locked,
  input  logic                      perout_error,
  output logic                      perout_enable,
  output logic [95:0]               perout_start,
  output logic                      perout_start_valid,
  output logic [95:0]               perout_period,
  output logic                      perout_period_valid,
  output logic [95:0]               perout_width,
  output logic                      perout_width_valid,
  output logic [2:0]                status_state,
  output logic                      status_running,
  output logic                      status_fault,
  output logic [7:0]                retry_count,
  output logic                      cfg_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_P    = 3'd1,
    LOAD_W    = 3'd2,
    LOAD_S    = 3'd3,
    WAIT_LOCK = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_e;

  localparam int            TW        = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(LOCK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cfg_loaded_q, cfg_loaded_d;
  logic [95:0]   period_sh_q, period_sh_d;
  logic [95:0]   width_sh_q, width_sh_d;
  logic [29:0]   phase_sh_q, phase_sh_d;
  logic          cfg_err_q, cfg_err_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          enable_q, enable_d;
  logic [95:0]   start_q, start_d;
  logic [95:0]   period_q, period_d;
  logic [95:0]   width_q, width_d;
  logic          start_v_q, start_v_d;
  logic          period_v_q, period_v_d;
  logic          width_v_q, width_v_d;

  logic cfg_accept, cfg_bad, cfg_good, retry_evt;
  logic ts_unused;

  assign ts_unused  = ^input_ts_96[47:0];
  assign cfg_accept = cfg_if.cfg_valid & cfg_ready_q;
  assign cfg_bad    = (cfg_if.cfg_period[95:48] == 48'd0) && (cfg_if.cfg_period[45:16] == 30'd0);
  assign cfg_good   = cfg_accept & ~cfg_bad;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    retry_evt    = 1'b0;
    cfg_loaded_d = cfg_loaded_q;
    period_sh_d  = period_sh_q;
    width_sh_d   = width_sh_q;
    phase_sh_d   = phase_sh_q;
    cfg_err_d    = cfg_accept & cfg_bad;

    if (cfg_good) begin
      period_sh_d  = cfg_if.cfg_period;
      width_sh_d   = cfg_if.cfg_width;
      phase_sh_d   = cfg_if.cfg_phase_ns;
      cfg_loaded_d = 1'b1;
    end

    unique case (state_q)
      IDLE:      if (enable_req && cfg_loaded_q) state_d = LOAD_P;
      LOAD_P:    state_d = LOAD_W;
      LOAD_W:    state_d = LOAD_S;
      LOAD_S: begin
        timer_d = '0;
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        timer_d = timer_q + 1'b1;
        if (perout_locked) begin
          state_d = RUN;
          retry_d = 8'd0;
        end else if (perout_error || (timer_q == TIMER_MAX)) begin
          retry_evt = 1'b1;
        end
      end
      RUN: begin
        // A time step invalidates the start time but is not a failure.
        if (input_ts_step)     state_d = LOAD_S;
        else if (perout_error) retry_evt = 1'b1;
        else if (cfg_good) begin
          state_d = LOAD_P;
          retry_d = 8'd0;
        end
      end
      FAULT:     state_d = FAULT;
      default:   state_d = IDLE;
    endcase

    if (retry_evt) begin
      if (32'(retry_q) < MAX_RETRY) begin
        retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        state_d = LOAD_S;
      end else begin
        state_d = FAULT;
      end
    end

    if (!enable_req) begin
      state_d = IDLE;
      retry_d = 8'd0;
    end

    // Strobes are registered so they are high exactly while the FSM sits in the load state.
    period_v_d  = (state_d == LOAD_P);
    width_v_d   = (state_d == LOAD_W);
    start_v_d   = (state_d == LOAD_S);
    period_d    = period_v_d ? period_sh_d : period_q;
    width_d     = width_v_d  ? width_sh_d  : width_q;
    start_d     = start_v_d  ? {input_ts_96[95:48] + LEAD_S, 2'b00, phase_sh_d, 16'h0000}
                             : start_q;
    cfg_ready_d = (state_d == IDLE) || (state_d == RUN) || (state_d == FAULT);
    enable_d    = (state_d != IDLE) && (state_d != FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      retry_q      <= 8'd0;
      timer_q      <= '0;
      cfg_loaded_q <= 1'b0;
      period_sh_q  <= '0;
      width_sh_q   <= '0;
      phase_sh_q   <= '0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b0;
      enable_q     <= 1'b0;
      start_q      <= '0;
      period_q     <= '0;
      width_q      <= '0;
      start_v_q    <= 1'b0;
      period_v_q   <= 1'b0;
      width_v_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      cfg_loaded_q <= cfg_loaded_d;
      period_sh_q  <= period_sh_d;
      width_sh_q   <= width_sh_d;
      phase_sh_q   <= phase_sh_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= cfg_ready_d;
      enable_q     <= enable_d;
      start_q      <= start_d;
      period_q     <= period_d;
      width_q      <= width_d;
      start_v_q    <= start_v_d;
      period_v_q   <= period_v_d;
      width_v_q    <= width_v_d;
    end
  end

  assign cfg_if.cfg_ready    = cfg_ready_q;
  assign perout_enable       = enable_q;
  assign perout_start        = start_q;
  assign perout_start_valid  = start_v_q;
  assign perout_period       = period_q;
  assign perout_period_valid = period_v_q;
  assign perout_width        = width_q;
  assign perout_width_valid  = width_v_q;
  assign status_state        = state_q;
  assign status_running      = (state_q == RUN);
  assign status_fault        = (state_q == FAULT);
  assign retry_count         = retry_q;
  assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_ptp_perout_ctrl.sv
// Self-checking bench for ptp_perout_ctrl: a strobe monitor pops expected
// loads from a queue; scenario tasks check FSM, retry and reset behaviour.
`timescale 1ns/1ps
module tb_ptp_perout_ctrl;
  localparam int          LT   = 16;
  localparam int          MR   = 3;
  localparam logic [47:0] LEAD = 48'd2;
  localparam int          W    = 98;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] ts_s;
  logic [95:0] input_ts_96;
  logic        input_ts_step, enable_req, perout_locked, perout_error;
  logic        perout_enable, perout_start_valid, perout_period_valid, perout_width_valid;
  logic [95:0] perout_start, perout_period, perout_width;
  logic [2:0]  status_state;
  logic        status_running, status_fault, cfg_err;
  logic [7:0]  retry_count;

  assign input_ts_96 = {ts_s, 2'b00, 30'd123456, 16'h0007};

  ptp_perout_ctrl_if cfg_if ();

  ptp_perout_ctrl #(.LEAD_S(LEAD), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .input_ts_96(input_ts_96), .input_ts_step(input_ts_step),
    .enable_req(enable_req), .cfg_if(cfg_if), .perout_locked(perout_locked),
    .perout_error(perout_error), .perout_enable(perout_enable),
    .perout_start(perout_start), .perout_start_valid(perout_start_valid),
    .perout_period(perout_period), .perout_period_valid(perout_period_valid),
    .perout_width(perout_width), .perout_width_valid(perout_width_valid),
    .status_state(status_state), .status_running(status_running),
    .status_fault(status_fault), .retry_count(retry_count), .cfg_err(cfg_err)
  );

  // scoreboard: {kind, value}; kind 1=period 2=width 3=start
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [95:0] cur_period, cur_width;
  logic [29:0] cur_phase;

  function automatic logic [95:0] mk_start(input logic [47:0] s, input logic [29:0] ph);
    logic [47:0] sum;
    sum = s + LEAD;
    return {sum, 2'b00, ph, 16'h0000};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    int nv;
    nv = int'(perout_period_valid) + int'(perout_width_valid) + int'(perout_start_valid);
    if (nv > 1) begin
      n_cmp++; n_err++;
      $display("FAIL strobe_excl: %0d strobes high, required at most 1", nv);
    end else if (nv == 1) begin
      if (perout_period_valid)     got = {2'd1, perout_period};
      else if (perout_width_valid) got = {2'd2, perout_width};
      else                         got = {2'd3, perout_start};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got %h, required no strobe", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL strobe_value: got %h, required %h", got, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic send_cfg(input logic [95:0] p, input logic [95:0] w, input logic [29:0] ph);
    int k = 0;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_period = p; cfg_if.cfg_width = w; cfg_if.cfg_phase_ns = ph;
    while (!cfg_if.cfg_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin n_cmp++; n_err++; $display("FAIL cfg_ready_timeout: ready=0, required 1"); end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    int k = 0;
    while (status_state !== s && k < bound) begin @(negedge clk); k++; end
    n_cmp++;
    if (status_state !== s) begin
      n_err++;
      $display("FAIL %s: state=%0d, required %0d", name, status_state, s);
    end
  endtask

  task automatic push_loads(input logic [47:0] s);
    exp_q.push_back({2'd1, cur_period});
    exp_q.push_back({2'd2, cur_width});
    exp_q.push_back({2'd3, mk_start(s, cur_phase)});
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({status_state, perout_enable, cfg_if.cfg_ready, retry_count, cfg_err, status_running, status_fault} !== 16'd0) begin
      n_err++; $display("FAIL reset_ctrl: state=%0d en=%b rdy=%b retry=%0d", status_state, perout_enable, cfg_if.cfg_ready, retry_count);
    end
    n_cmp++;
    if ({perout_start, perout_period, perout_width} !== 288'd0) begin
      n_err++; $display("FAIL reset_values: start=%h period=%h width=%h, required 0", perout_start, perout_period, perout_width);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    ts_s = 48'd10;
    cur_period = {48'd1, 48'd0};
    cur_width  = {48'd0, 2'b00, 30'd1000, 16'h0000};
    cur_phase  = 30'd500;
    push_loads(ts_s);
    enable_req = 1'b1;
    send_cfg(cur_period, cur_width, cur_phase);
    wait_state(3'd1, 10, "basic_load_p");
    n_cmp++;
    if (perout_period_valid !== 1'b1 || perout_enable !== 1'b1) begin
      n_err++; $display("FAIL basic_p_strobe: pv=%b en=%b, required 1 1", perout_period_valid, perout_enable);
    end
    @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd2 || perout_width_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_w: state=%0d wv=%b, required 2 1", status_state, perout_width_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd3 || perout_start !== {48'd12, 2'b00, 30'd500, 16'h0000}) begin
      n_err++; $display("FAIL basic_start: state=%0d start=%h", status_state, perout_start);
    end
    @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd4) begin n_err++; $display("FAIL basic_wait: state=%0d, required 4", status_state); end
    perout_locked = 1'b1;
    @(negedge clk);
    perout_locked = 1'b0;
    n_cmp++;
    if (status_state !== 3'd5 || status_running !== 1'b1 || perout_period !== cur_period) begin
      n_err++; $display("FAIL basic_run: state=%0d run=%b period=%h", status_state, status_running, perout_period);
    end
  endtask

  task automatic test_cfg_err();
    send_cfg({48'd0, 2'b00, 30'd0, 16'h1234}, {48'd0, 2'b00, 30'd777, 16'h0}, 30'd999);
    n_cmp++;
    if (cfg_err !== 1'b1 || status_state !== 3'd5) begin
      n_err++; $display("FAIL cfg_err_pulse: err=%b state=%0d, required 1 5", cfg_err, status_state);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_err !== 1'b0 || status_state !== 3'd5) begin
      n_err++; $display("FAIL cfg_err_clear: err=%b state=%0d, required 0 5", cfg_err, status_state);
    end
  endtask

  task automatic test_step_error();
    ts_s = 48'd100;
    @(negedge clk);
    exp_q.push_back({2'd3, mk_start(ts_s, cur_phase)});
    input_ts_step = 1'b1; perout_error = 1'b1;
    @(negedge clk);
    input_ts_step = 1'b0; perout_error = 1'b0;
    n_cmp++;
    if (status_state !== 3'd3 || retry_count !== 8'd0) begin
      n_err++; $display("FAIL step_prio: state=%0d retry=%0d, required 3 0", status_state, retry_count);
    end
    wait_state(3'd4, 3, "step_wait");
    perout_locked = 1'b1;
    @(negedge clk);
    perout_locked = 1'b0;
    exp_q.push_back({2'd3, mk_start(ts_s, cur_phase)});
    perout_error = 1'b1;
    @(negedge clk);
    perout_error = 1'b0;
    n_cmp++;
    if (status_state !== 3'd3 || retry_count !== 8'd1) begin
      n_err++; $display("FAIL error_retry: state=%0d retry=%0d, required 3 1", status_state, retry_count);
    end
    wait_state(3'd4, 3, "error_wait");
    perout_locked = 1'b1;
    @(negedge clk);
    perout_locked = 1'b0;
    n_cmp++;
    if (status_state !== 3'd5 || retry_count !== 8'd0) begin
      n_err++; $display("FAIL lock_clears_retry: state=%0d retry=%0d, required 5 0", status_state, retry_count);
    end
  endtask

  task automatic test_new_cfg();
    cur_period = {48'd2, 2'b00, 30'd250, 16'h0000};
    cur_width  = {48'd0, 2'b00, 30'd500, 16'h0000};
    cur_phase  = 30'($urandom_range(1, 999_999_999));
    push_loads(ts_s);
    send_cfg(cur_period, cur_width, cur_phase);
    n_cmp++;
    if (status_state !== 3'd1) begin n_err++; $display("FAIL run_cfg_reload: state=%0d, required 1", status_state); end
    wait_state(3'd4, 5, "run_cfg_wait");
    perout_locked = 1'b1;
    @(negedge clk);
    perout_locked = 1'b0;
    wait_state(3'd5, 2, "run_cfg_run");
  endtask

  task automatic test_timeout();
    int t[8];
    int n = 0;
    logic [2:0] prev = 3'd5;
    @(negedge clk);
    enable_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd0 || retry_count !== 8'd0 || perout_enable !== 1'b0) begin
      n_err++; $display("FAIL disable_idle: state=%0d retry=%0d en=%b", status_state, retry_count, perout_enable);
    end
    push_loads(ts_s);
    for (int i = 0; i < MR; i++) exp_q.push_back({2'd3, mk_start(ts_s, cur_phase)});
    enable_req = 1'b1;
    for (int c = 0; c < 5 * (LT + 1) + 20; c++) begin
      @(negedge clk);
      if (status_state == 3'd3 && prev != 3'd3 && n < 8) begin t[n] = c; n++; end
      prev = status_state;
      if (status_state == 3'd6) break;
    end
    n_cmp++;
    if (n !== MR + 1) begin n_err++; $display("FAIL timeout_loads: got %0d LOAD_S entries, required %0d", n, MR + 1); end
    for (int i = 1; i < n && i < MR + 1; i++) begin
      n_cmp++;
      if (t[i] - t[i-1] !== LT + 1) begin
        n_err++; $display("FAIL timeout_interval%0d: got %0d cycles, required %0d", i, t[i] - t[i-1], LT + 1);
      end
    end
    n_cmp++;
    if (status_state !== 3'd6 || status_fault !== 1'b1 || perout_enable !== 1'b0 || retry_count !== 8'(MR)) begin
      n_err++; $display("FAIL fault_entry: state=%0d fault=%b en=%b retry=%0d", status_state, status_fault, perout_enable, retry_count);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd6) begin n_err++; $display("FAIL fault_sticky: state=%0d, required 6", status_state); end
    enable_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd0 || retry_count !== 8'd0) begin
      n_err++; $display("FAIL fault_exit: state=%0d retry=%0d, required 0 0", status_state, retry_count);
    end
  endtask

  task automatic test_wrap();
    ts_s = 48'hFFFF_FFFF_FFFF;
    push_loads(ts_s);
    enable_req = 1'b1;
    wait_state(3'd3, 10, "wrap_load_s");
    n_cmp++;
    if (perout_start[95:48] !== 48'd1) begin
      n_err++; $display("FAIL wrap_seconds: got %0d, required 1", perout_start[95:48]);
    end
    @(negedge clk);
    perout_locked = 1'b1;
    @(negedge clk);
    perout_locked = 1'b0;
    wait_state(3'd5, 2, "wrap_run");
  endtask

  task automatic test_async_reset();
    ts_s = 48'd500;
    exp_q.push_back({2'd3, mk_start(ts_s, cur_phase)});
    input_ts_step = 1'b1;
    @(negedge clk);
    input_ts_step = 1'b0;
    wait_state(3'd4, 3, "ar_wait_lock");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({status_state, perout_enable, retry_count, status_running} !== 13'd0 ||
        {perout_start, perout_period, perout_width} !== 288'd0) begin
      n_err++; $display("FAIL async_reset: state=%0d en=%b start=%h period=%h", status_state, perout_enable, perout_start, perout_period);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (status_state !== 3'd0 || perout_enable !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: state=%0d en=%b, required 0 0", status_state, perout_enable);
    end
  endtask

  initial begin
    ts_s = 48'd0; input_ts_step = 1'b0; enable_req = 1'b0;
    perout_locked = 1'b0; perout_error = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0; cfg_if.cfg_width = '0; cfg_if.cfg_phase_ns = '0;
    cur_period = '0; cur_width = '0; cur_phase = '0;
    test_reset();
    test_basic();
    test_cfg_err();
    test_step_error();
    test_new_cfg();
    test_timeout();
    test_wrap();
    test_async_reset();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d loads outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
